// File: rtl/serial_pattern_detector.sv
// Serial LEN-bit pattern detector: overlapping matches, fill-gated so reset-zero
// history never fakes a match, with a saturating match counter and sticky overflow.
module serial_pattern_detector #(
  parameter int               LEN     = 4,
  parameter logic [LEN-1:0]   PATTERN = 4'b1011,
  parameter int               COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               din,
  input  logic               sample_en,
  input  logic               clear,
  output logic               match,
  output logic [COUNT_W-1:0] match_count,
  output logic               overflow,
  output logic               primed
);

  localparam int                 FW   = $clog2(LEN + 1);
  localparam logic [FW-1:0]      FULL = FW'(LEN);
  localparam logic [COUNT_W-1:0] CMAX = '1;

  logic [LEN-1:0] hist, hist_nxt;
  logic [FW-1:0]  fill, fill_nxt;
  logic           hit;

  // Match is judged on the history as it will be after this sample.
  always_comb begin
    hist_nxt = {hist[LEN-2:0], din};
    fill_nxt = (fill == FULL) ? fill : fill + FW'(1);
    hit      = (hist_nxt == PATTERN) && (fill_nxt == FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist        <= '0;
      fill        <= '0;
      match       <= 1'b0;
      match_count <= '0;
      overflow    <= 1'b0;
      primed      <= 1'b0;
    end else if (clear) begin
      hist        <= '0;
      fill        <= '0;
      match       <= 1'b0;
      match_count <= '0;
      overflow    <= 1'b0;
      primed      <= 1'b0;
    end else if (sample_en) begin
      hist   <= hist_nxt;
      fill   <= fill_nxt;
      primed <= (fill_nxt == FULL);
      match  <= hit;
      if (hit) begin
        if (match_count != CMAX) match_count <= match_count + COUNT_W'(1);
        else                     overflow    <= 1'b1;
      end
    end else begin
      match <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Directed bench for serial_pattern_detector: three configurations share one
// stimulus stream and are checked every cycle against a sample-history model.
module tb_serial_pattern_detector;

  logic clk = 1'b0;
  logic rst_n, din, sample_en, clear;
  logic [2:0] m_w, ovf_w, pr_w;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_pattern_detector #(.LEN(4), .PATTERN(4'b1011), .COUNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .din(din), .sample_en(sample_en), .clear(clear),
    .match(m_w[0]), .match_count(cnt0), .overflow(ovf_w[0]), .primed(pr_w[0]));
  serial_pattern_detector #(.LEN(4), .PATTERN(4'b0011), .COUNT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .din(din), .sample_en(sample_en), .clear(clear),
    .match(m_w[1]), .match_count(cnt1), .overflow(ovf_w[1]), .primed(pr_w[1]));
  serial_pattern_detector #(.LEN(2), .PATTERN(2'b11), .COUNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .din(din), .sample_en(sample_en), .clear(clear),
    .match(m_w[2]), .match_count(cnt2), .overflow(ovf_w[2]), .primed(pr_w[2]));

  // Model: total samples, total (unsaturated) matches, recent sampled bits.
  int mlen [3] = '{4, 4, 2};
  int mpat [3] = '{11, 3, 3};
  int mmax [3] = '{255, 255, 3};
  int nsamp[3];
  int nmatch[3];
  logic [31:0] mbits[3];
  bit mm[3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      nsamp[i] = 0; nmatch[i] = 0; mbits[i] = '0; mm[i] = 1'b0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      for (int i = 0; i < 3; i++) begin
        if (!rst_n || clear) begin
          nsamp[i] = 0; nmatch[i] = 0; mbits[i] = '0; mm[i] = 1'b0;
        end else if (sample_en) begin
          mbits[i] = {mbits[i][30:0], din};
          if (nsamp[i] < 100) nsamp[i]++;
          mm[i] = (nsamp[i] >= mlen[i]) &&
                  ((mbits[i] & ((32'd1 << mlen[i]) - 1)) == 32'(mpat[i]));
          if (mm[i]) nmatch[i]++;
        end else begin
          mm[i] = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int cnt_of(input int i);
    case (i)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  // Per-cycle compare against the model, away from the clock edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("match%0d", i), int'(m_w[i]), int'(mm[i]));
        chk($sformatf("count%0d", i), cnt_of(i),
            (nmatch[i] > mmax[i]) ? mmax[i] : nmatch[i]);
        chk($sformatf("ovf%0d", i), int'(ovf_w[i]), int'(nmatch[i] > mmax[i]));
        chk($sformatf("primed%0d", i), int'(pr_w[i]), int'(nsamp[i] >= mlen[i]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic smp(input logic d, input logic en, input logic c);
    @(negedge clk);
    din = d; sample_en = en; clear = c;
    @(posedge clk);
    #3;
  endtask

  initial begin
    rst_n = 1'b0; din = 1'b0; sample_en = 1'b0; clear = 1'b0;
    // Reset held with toggling inputs
    for (int k = 0; k < 4; k++) smp(k[0], 1'b1, 1'b0);
    chk("rst_match0", int'(m_w[0]), 0);
    chk("rst_count0", int'(cnt0), 0);
    chk("rst_primed0", int'(pr_w[0]), 0);
    chk("rst_ovf2", int'(ovf_w[2]), 0);
    @(negedge clk); rst_n = 1'b1; sample_en = 1'b0;
    smp(1'b1, 1'b0, 1'b0);
    smp(1'b0, 1'b0, 1'b0);
    chk("idle_count0", int'(cnt0), 0);

    // Overlap: 1011011 on PATTERN 1011
    smp(1,1,0); smp(0,1,0); smp(1,1,0);
    chk("ovl_primed_pre", int'(pr_w[0]), 0);
    smp(1,1,0);
    chk("ovl_match4", int'(m_w[0]), 1);
    chk("ovl_primed4", int'(pr_w[0]), 1);
    smp(0,1,0);
    chk("ovl_match5", int'(m_w[0]), 0);
    smp(1,1,0); smp(1,1,0);
    chk("ovl_match7", int'(m_w[0]), 1);
    chk("ovl_count", int'(cnt0), 2);
    smp(0,0,0);
    chk("ovl_pulse_end", int'(m_w[0]), 0);

    // Fill gating on PATTERN 0011
    smp(0,0,1);
    smp(1,1,0); smp(1,1,0);
    chk("fill_match", int'(m_w[1]), 0);
    chk("fill_primed", int'(pr_w[1]), 0);
    smp(0,1,0); smp(0,1,0); smp(1,1,0); smp(1,1,0);
    chk("fill_match_last", int'(m_w[1]), 1);
    chk("fill_count", int'(cnt1), 1);

    // Gapped 1011 with din toggling while sample_en is low
    smp(0,0,1);
    smp(1,1,0); smp(0,0,0); smp(0,1,0); smp(1,0,0);
    smp(1,1,0); smp(0,0,0); smp(1,1,0);
    chk("gap_match", int'(m_w[0]), 1);
    chk("gap_count", int'(cnt0), 1);

    // Clear beats a simultaneous sample
    smp(1,1,1);
    chk("clr_count", int'(cnt0), 0);
    chk("clr_primed", int'(pr_w[0]), 0);
    chk("clr_match", int'(m_w[0]), 0);
    smp(0,1,0); smp(1,1,0); smp(1,1,0);
    chk("clr_discard", int'(m_w[0]), 0);
    smp(1,1,0); smp(0,1,0); smp(1,1,0); smp(1,1,0);
    chk("clr_full4", int'(m_w[0]), 1);
    chk("clr_count1", int'(cnt0), 1);

    // Saturation on COUNT_W=2, PATTERN 11
    smp(0,0,1);
    smp(1,1,0);
    chk("sat_match1", int'(m_w[2]), 0);
    for (int k = 0; k < 3; k++) smp(1,1,0);
    chk("sat_count4", int'(cnt2), 3);
    chk("sat_ovf4", int'(ovf_w[2]), 0);
    smp(1,1,0);
    chk("sat_ovf5", int'(ovf_w[2]), 1);
    smp(1,1,0);
    chk("sat_match6", int'(m_w[2]), 1);
    chk("sat_count6", int'(cnt2), 3);
    smp(0,0,0); smp(0,1,0);
    chk("sat_ovf_sticky", int'(ovf_w[2]), 1);
    smp(0,0,1);
    chk("sat_ovf_clr", int'(ovf_w[2]), 0);

    // Mid-stream reset: history discarded, restart from fill = 0
    smp(1,1,0); smp(0,1,0); smp(1,1,0);
    @(negedge clk); rst_n = 1'b0; sample_en = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    smp(1,1,0);
    chk("mrst_match", int'(m_w[0]), 0);
    chk("mrst_count", int'(cnt0), 0);
    chk("mrst_primed", int'(pr_w[0]), 0);
    smp(0,1,0); smp(1,1,0);
    chk("mrst_primed3", int'(pr_w[0]), 0);
    smp(1,1,0);
    chk("mrst_primed4", int'(pr_w[0]), 1);
    chk("mrst_match4", int'(m_w[0]), 1);
    smp(0,0,0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
